// File: rtl/envelope_config_writer.sv
// Host-side config writer for the envelope attenuator: buffers commands in a small FIFO
// and turns each one into a one-hot write strobe, or a full-range sweep for broadcasts.
module envelope_config_writer #(
    parameter int NUM_VOICE_OPERATORS = 256,
    parameter int VOP_WIDTH           = 8,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_CmdValid,
    output logic                 o_CmdReady,
    input  logic [2:0]           i_CmdParam,
    input  logic                 i_CmdBroadcast,
    input  logic [VOP_WIDTH-1:0] i_CmdAddr,
    input  logic [15:0]          i_CmdData,
    output logic [4:0]           o_EnvelopeConfigWriteEnable,
    output logic [VOP_WIDTH-1:0] o_ConfigWriteAddr,
    output logic [15:0]          o_ConfigWriteData,
    output logic                 o_CmdError,
    output logic                 o_Busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [VOP_WIDTH-1:0] SWEEP_LAST_M1 = VOP_WIDTH'(NUM_VOICE_OPERATORS - 2);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]           param;
        logic                 bcast;
        logic [VOP_WIDTH-1:0] addr;
        logic [15:0]          data;
    } cmd_t;

    typedef enum logic {IDLE, SWEEP} state_t;

    cmd_t                 fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    state_t               state_q, state_d;
    logic [4:0]           we_q, we_d;
    logic [VOP_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic                 err_q, err_d;
    logic [2:0]           param_q, param_d;
    logic                 fifo_full, fifo_empty, push, pop;
    cmd_t                 head;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fifo_full  = (wr_ptr_q - rd_ptr_q) == FIFO_FULL_CNT;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign o_CmdReady = ~fifo_full & ~i_Reset;
    assign push       = i_CmdValid & o_CmdReady;
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];

    function automatic logic [15:0] mask_data(input logic [2:0] param, input logic [15:0] data);
        if (param < 3'd2) return data & 16'h3FFF;
        return data & 16'h0FFF;
    endfunction

    always_comb begin
        state_d = state_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        param_d = param_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.param > 3'd4) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 5'b00001 << head.param;
                        data_d  = mask_data(head.param, head.data);
                        param_d = head.param;
                        if (head.bcast) begin
                            addr_d  = '0;
                            state_d = SWEEP;
                        end else begin
                            addr_d = head.addr;
                        end
                    end
                end
            end
            SWEEP: begin
                we_d   = 5'b00001 << param_q;
                addr_d = addr_q + 1'b1;
                // Leave on the edge that registers the final address so the next pop follows directly.
                if (addr_q == SWEEP_LAST_M1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{param: i_CmdParam, bcast: i_CmdBroadcast,
                                                   addr: i_CmdAddr, data: i_CmdData};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            param_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, push};
            rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, pop};
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            param_q  <= param_d;
        end
    end

    assign o_EnvelopeConfigWriteEnable = we_q;
    assign o_ConfigWriteAddr           = addr_q;
    assign o_ConfigWriteData           = data_q;
    assign o_CmdError                  = err_q;
    assign o_Busy                      = ~fifo_empty | (state_q != IDLE) | (|we_q);

endmodule

// File: doc/envelope_config_writer.md
Name: envelope_config_writer

Overview:
- Producer side of the envelope attenuator's config write port.
- Accepts host config commands over a valid/ready handshake and buffers them in a 4-entry FIFO.
- Decodes each command into a one-hot, single-cycle write strobe with address and data for the five envelope parameter memories.
- Supports broadcast commands that sweep one parameter across every voice operator.

Parameters:
- NUM_VOICE_OPERATORS, 256: number of voice operator slots; broadcast sweeps 0..NUM_VOICE_OPERATORS-1.
- VOP_WIDTH, 8: width of VoiceOperatorID_t, equal to clog2(NUM_VOICE_OPERATORS).
- FIFO_DEPTH, 4: command buffer entries; must be a power of 2 and at least 2.

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_CmdValid  input  1  command presented.
- o_CmdReady  output  1  FIFO can accept a command; equals not-full.
- i_CmdParam  input  3  0=AttackLevel, 1=SustainLevel, 2=AttackRate, 3=DecayRate, 4=ReleaseRate; 5-7 are invalid.
- i_CmdBroadcast  input  1  write all voice operators and ignore i_CmdAddr.
- i_CmdAddr  input  VOP_WIDTH  target voice operator.
- i_CmdData  input  16  parameter value.
- o_EnvelopeConfigWriteEnable  output  5  one-hot write strobe, bit index equals param.
- o_ConfigWriteAddr  output  VOP_WIDTH  write address.
- o_ConfigWriteData  output  16  masked write data.
- o_CmdError  output  1  one-cycle pulse when an invalid-param command is consumed.
- o_Busy  output  1  FIFO non-empty, OR state is not IDLE, OR a strobe is active.

Behaviour:
- Reset:
  - FIFO is emptied and state goes to IDLE.
  - o_EnvelopeConfigWriteEnable=0, o_ConfigWriteAddr=0, o_ConfigWriteData=0, o_CmdError=0.
  - o_CmdReady=1 in the cycle after reset deasserts; o_CmdReady=0 while i_Reset is high.
  - Reset mid-sweep aborts the sweep immediately; no further strobes are issued.
- Handshake:
  - A command is accepted on a rising edge where i_CmdValid and o_CmdReady are both high.
  - o_CmdReady depends only on FIFO occupancy; it is never combinationally dependent on i_CmdValid.
  - No push occurs when the FIFO is full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when the FIFO is not full is legal; occupancy is unchanged.
- States:
  - IDLE:
    - If the FIFO is non-empty, pop the head at the next edge.
    - Valid single command: register the strobe, address and data, stay in IDLE. This gives one write per cycle sustained.
    - Valid broadcast command: register the strobe with addr=0, load the sweep counter, go to SWEEP.
    - Invalid param (single or broadcast): no strobe, pulse o_CmdError, stay in IDLE.
  - SWEEP:
    - Each cycle, emit a strobe for the same param and data with the address incremented by 1.
    - After the strobe with addr=NUM_VOICE_OPERATORS-1, return to IDLE. The next pop may occur on that same edge.
    - No pops occur during SWEEP; the FIFO keeps accepting until full.
- Latency:
  - If the command is accepted at edge k with the FIFO empty and state IDLE, the strobe is high from edge k+1 to edge k+2.
  - No FIFO fall-through.
- Strobe rules:
  - At most one bit set.
  - High exactly one cycle per write; outputs are driven directly from flops.
  - When no strobe is active, addr and data hold their last values.
- Data masking:
  - Params 0-1 (levels): data[15:14] forced to 0.
  - Params 2-4 (rates): data[15:12] forced to 0.
- Broadcast sweep length is exactly NUM_VOICE_OPERATORS strobes. The counter must not wrap into a second pass.

Test Plan:
- Reset, then accept {param=2, addr=5, data=16'hFFFF} at edge k -> at edge k+1, strobe=5'b00100, addr=5, data=16'h0FFF for exactly 1 cycle; o_Busy falls after it.
- 4 back-to-back singles, params 0..3 with addrs 1..4 -> 4 consecutive strobes 00001, 00010, 00100, 01000 with addrs 1..4; no gaps.
- Broadcast {param=4, data=16'h0123} followed by 5 singles:
  - Sweep strobes 10000 for addrs 0..255 on 256 consecutive cycles.
  - o_CmdReady drops after the FIFO fills with 4 entries; the 5th command waits.
  - The first queued single's strobe occurs on the cycle immediately after addr 255.
- Command with param=6, addr=9 -> o_CmdError pulses 1 cycle, strobe stays 0, FIFO drains; a following valid command is written normally.
- Assert i_Reset at sweep addr 100 -> no strobe in the cycle after the reset edge; all outputs 0; FIFO empty; o_CmdReady=1 after reset release.
- Push and pop in the same cycle with occupancy 2 -> occupancy stays 2; command order is preserved, checked against a scoreboard.
